// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_trx transceiver.
// Optional even parity is enabled with UART_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int BAUD_DIV_MIN = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_trx_if.sv
// Byte-stream valid/ready bundle between the fabric and uart_trx.
// slave = transceiver side, master = fabric side.
interface uart_trx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_data_vld_i;
  logic                 tx_data_rdy_o;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_data_vld_o;
  logic                 rx_data_rdy_i;

  modport slave (
    input  tx_data_i, tx_data_vld_i, rx_data_rdy_i,
    output tx_data_rdy_o, rx_data_o, rx_data_vld_o
  );

  modport master (
    output tx_data_i, tx_data_vld_i, rx_data_rdy_i,
    input  tx_data_rdy_o, rx_data_o, rx_data_vld_o
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: tick_o pulses n_i cycles after load_i.
// A load in the tick cycle restarts the count (load wins).
module uart_bit_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] n_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  assign tick_o = run_q & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = n_i - W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/uart_trx.sv
// Full-duplex UART transceiver, 8N1 (8E1 when UART_PARITY_EN).
// TX and RX share the runtime divider but run independently.
module uart_trx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV_W  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BAUD_DIV_W-1:0] baud_div_i,
  input  logic                  uart_rx_i,
  output logic                  uart_tx_o,
  uart_trx_if.slave             bus
);

  typedef logic [BAUD_DIV_W-1:0] div_t;

  div_t p_eff;
  assign p_eff = (baud_div_i < div_t'(BAUD_DIV_MIN))
               ? div_t'(BAUD_DIV_MIN) : baud_div_i;

  tx_state_t  tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  div_t       tx_div_q, tx_div_d;
  logic       tx_line_q, tx_line_d;
  logic       tx_load, tx_tick;
  div_t       tx_ld_val;
`ifdef UART_PARITY_EN
  logic       tx_par_q, tx_par_d;
`endif

  uart_bit_timer #(.W(BAUD_DIV_W)) u_tx_tmr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tx_load),
    .n_i    (tx_ld_val),
    .tick_o (tx_tick)
  );

  assign uart_tx_o         = tx_line_q;
  assign bus.tx_data_rdy_o = (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_load    = 1'b0;
    tx_ld_val  = tx_div_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      TX_IDLE: if (bus.tx_data_vld_i) begin
        tx_state_d = TX_START;
        tx_shift_d = bus.tx_data_i;
        tx_div_d   = p_eff;
        tx_load    = 1'b1;
        tx_ld_val  = p_eff;
`ifdef UART_PARITY_EN
        tx_par_d   = ^bus.tx_data_i;
`endif
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = '0;
        tx_load    = 1'b1;
      end
      TX_DATA: if (tx_tick) begin
        tx_load = 1'b1;
        if (tx_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          tx_state_d = TX_PARITY;
`else
          tx_state_d = TX_STOP;
`endif
        end else begin
          tx_cnt_d   = tx_cnt_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_tick) begin
        tx_state_d = TX_STOP;
        tx_load    = 1'b1;
      end
`endif
      TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    // line is registered from the next state so it never glitches
    tx_line_d = 1'b1;
    unique case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_line_d = tx_par_d;
`endif
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_div_q   <= div_t'(BAUD_DIV_MIN);
      tx_line_q  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_s, rx_prev_q;
  rx_state_t  rx_state_q, rx_state_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  div_t       rx_div_q, rx_div_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_vld_q, rx_vld_d;
  logic       rx_load, rx_tick, rx_new;
  div_t       rx_ld_val;
`ifdef UART_PARITY_EN
  logic       rx_par_ok_q, rx_par_ok_d;
`endif

  uart_bit_timer #(.W(BAUD_DIV_W)) u_rx_tmr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (rx_load),
    .n_i    (rx_ld_val),
    .tick_o (rx_tick)
  );

  assign rx_s              = sync_q[SYNC_STAGES-1];
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_data_vld_o = rx_vld_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_data_d  = rx_data_q;
    rx_load    = 1'b0;
    rx_ld_val  = rx_div_q;
    rx_new     = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_ok_d = rx_par_ok_q;
`endif
    unique case (rx_state_q)
      RX_IDLE: if (rx_prev_q & ~rx_s) begin
        rx_state_d = RX_START;
        rx_div_d   = p_eff;
        rx_load    = 1'b1;
        rx_ld_val  = p_eff >> 1;
      end
      RX_START: if (rx_tick) begin
        if (rx_s) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
          rx_load    = 1'b1;
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        rx_load    = 1'b1;
        if (rx_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          rx_state_d = RX_PARITY;
`else
          rx_state_d = RX_STOP;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + 3'd1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_tick) begin
        rx_par_ok_d = ((^rx_shift_q) == rx_s);
        rx_state_d  = RX_STOP;
        rx_load     = 1'b1;
      end
`endif
      RX_STOP: if (rx_tick) begin
        rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
        rx_new = rx_s & rx_par_ok_q;
`else
        rx_new = rx_s;
`endif
        if (rx_new) rx_data_d = rx_shift_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // a byte completing in the handshake cycle keeps vld high
    rx_vld_d = rx_vld_q & ~bus.rx_data_rdy_i;
    if (rx_new) rx_vld_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      rx_div_q   <= div_t'(BAUD_DIV_MIN);
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok_q <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
`ifdef UART_PARITY_EN
      rx_par_ok_q <= rx_par_ok_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_trx.sv
// Bench for uart_trx: loopback into RX, echo through a second
// transceiver, glitch/framing/reset/min-divider cases.
module tb_uart_trx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] baud = 32'd98;
  int          cur_p = 98;
  logic        a_tx, a_rx, b_tx;
  logic        rx_force = 1'b0;
  logic        rx_drv = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  int rx_cnt = 0;
  int cyc = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_ser[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_trx_if bus_a ();
  uart_trx_if bus_b ();

  assign a_rx = rx_force ? rx_drv : a_tx;
  assign bus_a.rx_data_rdy_i = bus_b.tx_data_rdy_o;
  assign bus_b.tx_data_i     = bus_a.rx_data_o;
  assign bus_b.tx_data_vld_i = bus_a.rx_data_vld_o;
  assign bus_b.rx_data_rdy_i = 1'b1;

  uart_trx #(.BAUD_DIV_W(32), .SYNC_STAGES(2)) u_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_div_i (baud),
    .uart_rx_i  (a_rx),
    .uart_tx_o  (a_tx),
    .bus        (bus_a)
  );

  uart_trx #(.BAUD_DIV_W(32), .SYNC_STAGES(2)) u_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_div_i (baud),
    .uart_rx_i  (1'b1),
    .uart_tx_o  (b_tx),
    .bus        (bus_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: A's received bytes, popped on each handshake
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_a.rx_data_vld_o && bus_a.rx_data_rdy_i) begin
      rx_cnt++;
      if (exp_rx.size() == 0) chk("rx unexpected byte", bus_a.rx_data_o, 0);
      else chk("rx byte", {24'd0, bus_a.rx_data_o}, {24'd0, exp_rx.pop_front()});
    end
  end

  // Monitor: decode B's echoed serial line
  initial begin
    logic [7:0] d;
    int p;
    forever begin
      @(negedge b_tx);
      if (rst === 1'b0) begin
        p = cur_p;
        repeat (p / 2) @(negedge clk);
        chk("ser start bit", {31'd0, b_tx}, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (p) @(negedge clk);
          d[i] = b_tx;
        end
        repeat (p) @(negedge clk);
        chk("ser stop bit", {31'd0, b_tx}, 1);
        if (exp_ser.size() == 0) chk("ser unexpected byte", {24'd0, d}, 0);
        else chk("ser byte", {24'd0, d}, {24'd0, exp_ser.pop_front()});
      end
    end
  end

  task automatic wait_rdy();
    int g = 0;
    @(negedge clk);
    while (!bus_a.tx_data_rdy_o && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) chk("tx rdy timeout", 0, 1);
  endtask

  task automatic send_checked(input logic [7:0] b, input string nm);
    logic [9:0] fr;
    int bad;
    fr = {1'b1, b, 1'b0};
    wait_rdy();
    bus_a.tx_data_i = b;
    bus_a.tx_data_vld_i = 1'b1;
    @(posedge clk);
    #1;
    bus_a.tx_data_vld_i = 1'b0;
    exp_rx.push_back(b);
    exp_ser.push_back(b);
    chk({nm, " low after handshake"}, {31'd0, a_tx}, 0);
    chk({nm, " rdy low"}, {31'd0, bus_a.tx_data_rdy_o}, 0);
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < cur_p; c++) begin
        if (a_tx !== fr[k]) bad++;
        if (k == 9 && c == cur_p - 1)
          chk({nm, " rdy low at last stop cycle"},
              {31'd0, bus_a.tx_data_rdy_o}, 0);
        @(posedge clk);
        #1;
      end
      chk($sformatf("%s bit%0d bad cycles", nm, k), bad, 0);
    end
    chk({nm, " rdy back after frame"}, {31'd0, bus_a.tx_data_rdy_o}, 1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (cur_p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (cur_p) @(negedge clk);
    end
    rx_drv = stop;
    repeat (cur_p) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin
    int i, g, t1, t2, c0;
    logic [9:0] pat61;
    bus_a.tx_data_i = 8'h00;
    bus_a.tx_data_vld_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset tx line", {31'd0, a_tx}, 1);
    chk("reset tx rdy", {31'd0, bus_a.tx_data_rdy_o}, 1);
    chk("reset rx vld", {31'd0, bus_a.rx_data_vld_o}, 0);
    chk("reset rx data", {24'd0, bus_a.rx_data_o}, 0);

    pat61 = 10'b1011000010;
    chk("frame 61 pattern", {22'd0, pat61}, {22'd0, 1'b1, 8'h61, 1'b0});
    send_checked(8'h61, "tx61");

    wait_rdy();
    i = 0;
    g = 0;
    t1 = 0;
    t2 = 0;
    bus_a.tx_data_i = 8'h61;
    bus_a.tx_data_vld_i = 1'b1;
    while (i < 16 && g < 20000) begin
      if (bus_a.tx_data_rdy_o) begin
        exp_rx.push_back(bus_a.tx_data_i);
        exp_ser.push_back(bus_a.tx_data_i);
        @(posedge clk);
        #1;
        if (i == 0) t1 = cyc;
        if (i == 1) t2 = cyc;
        i++;
        bus_a.tx_data_i = 8'h61 + 8'(i);
        if (i == 16) bus_a.tx_data_vld_i = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    bus_a.tx_data_vld_i = 1'b0;
    chk("stream accepted", i, 16);
    chk("back-to-back spacing", t2 - t1, 981);
    repeat (2500) @(posedge clk);
    chk("stream rx queue drained", exp_rx.size(), 0);

    rx_force = 1'b1;
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    c0 = rx_cnt;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1500) @(negedge clk);
    chk("glitch no vld", rx_cnt, c0);
    chk("glitch vld low", {31'd0, bus_a.rx_data_vld_o}, 0);

    drive_frame(8'h3C, 1'b0);
    repeat (3 * cur_p) @(negedge clk);
    chk("framing err discarded", rx_cnt, c0);
    chk("framing err vld low", {31'd0, bus_a.rx_data_vld_o}, 0);
    exp_rx.push_back(8'hA5);
    exp_ser.push_back(8'hA5);
    drive_frame(8'hA5, 1'b1);
    repeat (1500) @(negedge clk);
    chk("good frame after error", rx_cnt, c0 + 1);
    rx_force = 1'b0;
    repeat (1500) @(negedge clk);

    wait_rdy();
    bus_a.tx_data_i = 8'hFF;
    bus_a.tx_data_vld_i = 1'b1;
    @(posedge clk);
    #1;
    bus_a.tx_data_vld_i = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("busy before reset", {31'd0, bus_a.tx_data_rdy_o}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-frame reset line", {31'd0, a_tx}, 1);
    chk("mid-frame reset rdy", {31'd0, bus_a.tx_data_rdy_o}, 1);
    @(negedge clk);
    rst = 1'b0;
    send_checked(8'h00, "tx00");
    repeat (2500) @(negedge clk);

    baud = 32'd2;
    cur_p = 4;
    send_checked(8'h5A, "tx5A min div");
    repeat (300) @(negedge clk);

    chk("rx queue empty", exp_rx.size(), 0);
    chk("ser queue empty", exp_ser.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_trx.md
Name: uart_trx

Overview:
- Full-duplex 8N1 UART transceiver: one transmit engine and one receive engine in a single block.
- Both engines use the same runtime baud divider.
- Sits between a byte-stream valid/ready fabric (e.g. SoC debug/loader bus) and the external serial pins.
- The byte interfaces use a valid/ready handshake, so a received byte can be fed straight back into the transmit side for echo/loopback.

Parameters:
- BAUD_DIV_W, 32, width of the runtime baud divider input.
- SYNC_STAGES, 2, flip-flop stages in the rx line synchronizer (minimum 2).

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- baud_div_i  input  BAUD_DIV_W  clock cycles per serial bit; sampled at the start of each frame.
- uart_rx_i  input  1  serial receive line (asynchronous, idle high).
- uart_tx_o  output  1  serial transmit line (idle high).
- tx_data_i  input  8  byte to transmit.
- tx_data_vld_i  input  1  tx_data_i valid.
- tx_data_rdy_o  output  1  transmitter can accept a byte.
- rx_data_o  output  8  received byte.
- rx_data_vld_o  output  1  rx_data_o holds an unconsumed byte.
- rx_data_rdy_i  input  1  consumer accepts rx_data_o.

Behaviour:
- Reset values: uart_tx_o=1, tx_data_rdy_o=1, rx_data_vld_o=0, rx_data_o=8'h00. Both engines return to IDLE; a frame in flight is abandoned. Reset mid-frame drives uart_tx_o high the next cycle.
- Bit period: P = baud_div_i clocks. Values below 4 are treated as 4. P is latched at frame start; changes mid-frame take effect on the next frame.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1).
- TX states and transitions:
  - IDLE: rdy=1, line=1.
  - A transfer occurs on a cycle with tx_data_vld_i & tx_data_rdy_o. The byte is latched and the engine goes to START.
  - The next cycle, uart_tx_o=0 and rdy=0.
  - START (P cycles), then DATA bit0..bit7 (P cycles each), then STOP (P cycles, line=1), then IDLE.
  - rdy reasserts on the cycle after STOP completes. Total frame is 10P cycles.
  - Back-to-back: a vld held high is accepted on the first cycle rdy=1, giving a one-cycle idle gap between frames.
- RX states and transitions:
  - uart_rx_i passes through a SYNC_STAGES flip-flop synchronizer.
  - IDLE: wait for a synchronized falling edge (1 then 0), then go to START.
  - START: count P/2 (integer divide) cycles and sample. If the sample is 1 it is a glitch: return to IDLE.
  - DATA: then 8 samples, P cycles apart, shifted in LSB first.
  - STOP: one more sample P cycles later. If 1, load rx_data_o and assert rx_data_vld_o the next cycle. If 0 (framing error), discard the byte and do not assert vld.
  - After the stop sample the engine returns to IDLE immediately, ready for the next start edge.
- RX handshake:
  - rx_data_vld_o holds until a cycle with rx_data_vld_o & rx_data_rdy_i; it deasserts the following cycle.
  - rx_data_o is stable while vld=1.
  - Overrun: if a new valid byte completes while vld=1, rx_data_o is overwritten and vld stays 1.
  - A handshake and a new byte completing in the same cycle: the new byte wins and vld stays 1.
- TX and RX are fully independent; simultaneous activity on both is allowed.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: frame is 8E1, with an even-parity bit inserted after bit7 (frame = 11P). RX checks parity and discards the byte on mismatch, exactly like a framing error.
- Undefined: 8N1 as above; no parity logic is synthesized.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t (IDLE, START, DATA, PARITY, STOP) and rx_state_t (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8 and BAUD_DIV_MIN=4 constants.
- One sub-module, uart_bit_timer: loadable down-counter that emits a tick after N cycles. It is instantiated once for TX and once for RX.

Test Plan:
- Reset, then baud_div_i=98, send 8'h61 -> uart_tx_o low one cycle after handshake; bit pattern 0,1,0,0,0,0,1,1,0,1, each held 98 cycles; rdy returns after 980 cycles.
- Loop uart_tx_o to uart_rx_i with rx_data_rdy_i=1, stream 8'h61..8'h70 with vld held high -> rx_data_vld_o pulses one cycle per byte with incrementing values and no loss.
- Echo chain: rx_data_o/rx_data_vld_o feed a second transceiver's tx, whose tx_data_rdy_o drives rx_data_rdy_i -> second serial line reproduces the bytes in order.
- 20-cycle low glitch on uart_rx_i with baud_div_i=98 -> no rx_data_vld_o.
- Frame with stop bit forced 0 -> byte discarded, vld stays 0. Next good frame 8'hA5 is received correctly.
- Assert rst_i mid-transmit of 8'hFF -> uart_tx_o=1 and tx_data_rdy_o=1 the next cycle. A subsequent send of 8'h00 is framed correctly.
